echo_decoder: RTL and testbench
===============================

// Module: echo_decoder
// PURPOSE
//  Inverse of the pedal's feedback echo/drive stage. The forward stage computes y[n] = y[n-D] >>> SHIFT + x[n].
//  This block recovers the dry signal: x[n] = y[n] - (y[n-D] >>> SHIFT).
//  It keeps its own history of received samples in a RAM circular buffer, with D set at run time.
//  Sits after the drive stage, for measurement/bypass paths and self-check loopback.
// PARAMETERS
//  SAMPLE_W  16  audio sample width, two's complement
//  ADDR_W    10  history depth = 2**ADDR_W samples
//  SHIFT     2   feedback gain as an arithmetic right shift (1/4)
// PORTS
//  sample_clock   in   1         single clock, all logic on posedge
//  reset          in   1         synchronous, active-high
//  in_valid       in   1         input_sample valid this cycle
//  in_ready       out  1         block can accept a sample this cycle
//  input_sample   in   SAMPLE_W  wet (echoed) sample y[n]
//  delay_len      in   ADDR_W    echo delay D in samples; 0 = passthrough
//  output_sample  out  SAMPLE_W  recovered dry sample x[n]
//  out_valid      out  1         one-cycle pulse, output_sample new
//  overrun        out  1         sticky: in_valid seen while in_ready=0
// BEHAVIOUR
//  Reset values
//   - output_sample=0, out_valid=0, overrun=0, in_ready=0.
//   - wr_ptr=0; FSM goes to CLEAR.
//  FSM states: CLEAR -> IDLE -> READ -> CALC -> IDLE.
//   - CLEAR: writes 0 to every RAM address, 0..2**ADDR_W-1, one per cycle; in_ready=0.
//     Goes to IDLE after the last address. History is therefore zero after every reset.
//   - IDLE: in_ready=1.
//     On in_valid, registers input_sample and delay_len (D), then goes to READ.
//   - READ: issues a RAM read at (wr_ptr - D) mod 2**ADDR_W.
//   - CALC: RAM data is available (1-cycle synchronous read).
//     Computes dry = sample - (hist >>> SHIFT), sign-filled.
//     Subtraction wraps modulo 2**SAMPLE_W (no saturation), so the result is a bit-exact inverse of the wrapping adder in the drive stage.
//     If D==0, dry = sample.
//     Writes the registered sample to RAM[wr_ptr]; wr_ptr += 1, wrapping at 2**ADDR_W.
//     Registers output_sample=dry and out_valid=1.
//  Latency and throughput
//   - Accept in cycle t -> out_valid=1 in cycle t+3, for exactly one cycle.
//   - output_sample holds its value until the next out_valid.
//   - A new sample may be accepted in that same cycle t+3. Maximum rate is 1 sample per 3 cycles.
//  Boundary conditions
//   - in_valid while in_ready=0 (CLEAR/READ/CALC): sample dropped, overrun set to 1; only reset clears it.
//   - delay_len change: takes effect from the next accepted sample. The sample in flight uses its latched D.
//   - D can reach at most 2**ADDR_W-1, so the read slot is never the slot being written.
//   - Before D samples have been received, history reads return 0 (the effect of CLEAR).
//   - reset in any state, including mid-CLEAR or CALC: the in-flight sample is discarded with no out_valid.
//     CLEAR restarts from address 0.
//   - Single-port RAM is sufficient: the read (READ) and the write (CALC) never fall in the same cycle.
// STRUCTURE
//  - Shared package/include pedal_pkg: SAMPLE_W, default SHIFT, and the FSM state encodings shared with future pedal effects.
//  - Sub-module delay_ram: single-port synchronous RAM, 2**ADDR_W x SAMPLE_W.
//    Ports: sample_clock, addr, we, wdata, rdata; 1-cycle read latency.
//  - Top level contains the FSM, wr_ptr, CLEAR counter, datapath and overrun flag.
// TESTING
//  1. Reset release -> in_ready=0 for 1024 cycles (defaults), then 1; output_sample=0, out_valid=0, overrun=0 throughout.
//  2. D=4, inputs 16'h4000 then 16'h0000 x8 -> outputs 4000,0000,0000,0000,F000,0000...; out_valid exactly 3 cycles after each accept.
//  3. D=0, input 16'h1234 -> 16'h1234. D=1, inputs 8000,0000 -> 8000,2000 (0x8000>>>2 = E000, and 0 - E000 wraps to 2000).
//  4. Loopback: 2000 random x through a reference model of the drive stage (D=4, SHIFT=2, wrapping add) -> output equals x bit-exact, including overflow cases.
//  5. in_valid pulsed during READ -> sample ignored, no extra out_valid, overrun=1, stays 1 until reset.
//  6. Reset asserted in CALC after 16'h7FFF -> no out_valid. After CLEAR, D=4 impulse 16'h4000 -> echo appears only at sample 4, no residue of 7FFF.

Source files
------------

// File: rtl/pedal_pkg.sv
// Shared pedal definitions: sample width, default feedback shift and the FSM
// state encoding reused by the pedal effect blocks.
package pedal_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int SHIFT_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_CALC  = 2'd3
  } pedal_state_t;

endpackage

// File: rtl/delay_ram.sv
// Single-port synchronous RAM holding the echo history, 1-cycle read latency.
module delay_ram
  import pedal_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic              sample_clock,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write when enabled, otherwise read; rdata only moves on read cycles.
  always_ff @(posedge sample_clock) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/echo_decoder.sv
// Inverse of the feedback echo stage: x[n] = y[n] - (y[n-D] >>> SHIFT).
// History of received samples lives in a circular RAM, cleared after reset.
module echo_decoder
  import pedal_pkg::*;
#(
  parameter int SAMPLE_W = pedal_pkg::SAMPLE_W,
  parameter int ADDR_W   = 10,
  parameter int SHIFT    = SHIFT_DEFAULT
) (
  input  logic                sample_clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] input_sample,
  input  logic [ADDR_W-1:0]   delay_len,
  output logic [SAMPLE_W-1:0] output_sample,
  output logic                out_valid,
  output logic                overrun
);

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  pedal_state_t        state, state_next;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [SAMPLE_W-1:0] sample_q;
  logic [ADDR_W-1:0]   d_q;

  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [SAMPLE_W-1:0] ram_wdata;
  logic [SAMPLE_W-1:0] ram_rdata;

  logic [SAMPLE_W-1:0] hist_scaled;
  logic [SAMPLE_W-1:0] dry;

  delay_ram #(.ADDR_W(ADDR_W), .DATA_W(SAMPLE_W)) u_ram (
    .sample_clock (sample_clock),
    .addr         (ram_addr),
    .we           (ram_we),
    .wdata        (ram_wdata),
    .rdata        (ram_rdata)
  );

  // Sign-filled feedback term; subtraction wraps to mirror the drive stage's wrapping add.
  assign hist_scaled = SAMPLE_W'($signed(ram_rdata) >>> SHIFT);
  assign dry         = (d_q == '0) ? sample_q : sample_q - hist_scaled;

  // State register.
  always_ff @(posedge sample_clock) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_next;
  end

  // Next state, handshake and RAM port steering. Read and write never share a cycle.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ram_addr   = clr_cnt;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    case (state)
      ST_CLEAR: begin
        ram_we = 1'b1;
        if (clr_cnt == CLR_LAST) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        ram_addr = wr_ptr;
        if (in_valid) state_next = ST_READ;
      end
      ST_READ: begin
        ram_addr   = wr_ptr - d_q;
        state_next = ST_CALC;
      end
      ST_CALC: begin
        ram_addr   = wr_ptr;
        ram_we     = 1'b1;
        ram_wdata  = sample_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // Datapath: clear counter, input latch, write pointer, result and sticky overrun.
  always_ff @(posedge sample_clock) begin
    if (reset) begin
      clr_cnt       <= '0;
      wr_ptr        <= '0;
      sample_q      <= '0;
      d_q           <= '0;
      output_sample <= '0;
      out_valid     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == ST_IDLE && in_valid) begin
        sample_q <= input_sample;
        d_q      <= delay_len;
      end
      if (state == ST_CALC) begin
        output_sample <= dry;
        out_valid     <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (in_valid && !in_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_decoder.sv
// Bench for echo_decoder: table vectors, overrun/reset sequences and a
// loopback through a reference model of the forward drive stage.
module tb_echo_decoder;

  logic        sample_clock = 1'b0;
  logic        reset        = 1'b1;
  logic        in_valid     = 1'b0;
  logic [15:0] input_sample = '0;
  logic [9:0]  delay_len    = '0;
  logic        in_ready;
  logic [15:0] output_sample;
  logic        out_valid;
  logic        overrun;

  echo_decoder dut (
    .sample_clock  (sample_clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .input_sample  (input_sample),
    .delay_len     (delay_len),
    .output_sample (output_sample),
    .out_valid     (out_valid),
    .overrun       (overrun)
  );

  always #5 sample_clock = ~sample_clock;

  int cyc = 0;
  always @(posedge sample_clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] y;
    logic [9:0]  d;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[13];

  // forward drive-stage model state
  logic [15:0] yhist[1024];
  int          ywp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest expectation in data and cycle.
  always @(negedge sample_clock) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("output_sample", {16'h0, output_sample}, {16'h0, e.data});
        check("out_valid latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [15:0] y, input logic [9:0] d, input logic [15:0] exp);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge sample_clock);
      w++;
    end
    check("in_ready before send", {31'h0, in_ready}, 32'd1);
    in_valid     = 1'b1;
    input_sample = y;
    delay_len    = d;
    sb.push_back('{exp, cyc + 3});
    @(negedge sample_clock);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    int cnt = 0;
    int bad = 0;
    check("scoreboard drained", sb.size(), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge sample_clock);
    reset = 1'b0;
    while (!in_ready && cnt < 2000) begin
      cnt++;
      if (out_valid !== 1'b0 || overrun !== 1'b0 || output_sample !== 16'h0) bad++;
      @(negedge sample_clock);
    end
    check("clear cycles", cnt, 32'd1024);
    check("outputs quiet during clear", bad, 32'd0);
    check("output_sample after clear", {16'h0, output_sample}, 32'h0);
    check("overrun after reset", {31'h0, overrun}, 32'd0);
    for (int i = 0; i < 1024; i++) yhist[i] = '0;
    ywp = 0;
  endtask

  initial begin
    vt[0] = '{16'h4000, 10'd4, 16'h4000};
    for (int i = 1; i < 9; i++) vt[i] = '{16'h0000, 10'd4, 16'h0000};
    vt[4]  = '{16'h0000, 10'd4, 16'hF000};
    vt[9]  = '{16'h1234, 10'd0, 16'h1234};
    vt[10] = '{16'h0000, 10'd0, 16'h0000};
    vt[11] = '{16'h8000, 10'd1, 16'h8000};
    vt[12] = '{16'h0000, 10'd1, 16'h2000};

    // reset state and clear timing
    @(negedge sample_clock);
    do_reset();

    // impulse with D=4, then D=0 passthrough and D=1 wrap case
    for (int i = 0; i < 13; i++) send(vt[i].y, vt[i].d, vt[i].exp);

    // overrun: pulse in_valid while in READ
    send(16'h0055, 10'd0, 16'h0055);
    in_valid     = 1'b1;
    input_sample = 16'hBEEF;
    @(negedge sample_clock);
    in_valid = 1'b0;
    @(negedge sample_clock);
    check("overrun set", {31'h0, overrun}, 32'd1);
    send(16'h0011, 10'd0, 16'h0011);
    repeat (4) @(negedge sample_clock);
    check("overrun sticky", {31'h0, overrun}, 32'd1);

    // reset during CALC discards the in-flight sample
    while (!in_ready) @(negedge sample_clock);
    in_valid     = 1'b1;
    input_sample = 16'h7FFF;
    delay_len    = 10'd4;
    @(negedge sample_clock);
    in_valid = 1'b0;
    @(negedge sample_clock);
    do_reset();
    for (int i = 0; i < 6; i++) send(vt[i].y, vt[i].d, vt[i].exp);

    // loopback through the forward drive stage with wrapping add
    repeat (4) @(negedge sample_clock);
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] x, h, y;
      x = 16'($urandom);
      h = yhist[(ywp - 4) & 1023];
      y = 16'($signed(h) >>> 2) + x;
      yhist[ywp] = y;
      ywp = (ywp + 1) % 1024;
      send(y, 10'd4, x);
    end

    repeat (6) @(negedge sample_clock);
    check("scoreboard drained at end", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
